// File: rtl/req_fifo_pkg.sv
// ============================================================================
// Module   : req_fifo_pkg
// Brief    : Shared constants, FSM encoding and helpers for req_fifo_mc.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package req_fifo_pkg;

  localparam logic [7:0] DELIM_DEFAULT = 8'hEE;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

  // Channel-index width; a two-channel build still needs one bit.
  function automatic int chan_idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/req_fifo_chan.sv
// ============================================================================
// Module   : req_fifo_chan
// Brief    : One request queue: storage, pointers, occupancy, registered
//            free-space report and complete-request counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module req_fifo_chan
  import req_fifo_pkg::*;
#(
  parameter int         WIDTH = 64,
  parameter int         DEPTH = 3,
  parameter logic [7:0] DELIM = DELIM_DEFAULT
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_wr,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic             o_full,
  output logic             o_nempty,
  output logic [DEPTH:0]   o_space,
  output logic             o_req_pend,
  output logic [WIDTH-1:0] o_head
);

  localparam logic [DEPTH:0] C_CAP = {1'b1, {DEPTH{1'b0}}};

  logic [WIDTH-1:0] r_mem [2**DEPTH];
  logic [DEPTH-1:0] r_wptr;
  logic [DEPTH-1:0] r_rptr;
  logic [DEPTH:0]   r_occ;
  logic [DEPTH:0]   r_space;
  logic [DEPTH:0]   r_req_cnt;
  logic [DEPTH:0]   w_occ_nxt;
  logic             w_wr_acc;
  logic             w_rd_acc;
  logic             w_inc;
  logic             w_dec;

  assign o_full     = (r_occ == C_CAP);
  assign o_nempty   = (r_occ != '0);
  assign o_space    = r_space;
  assign o_req_pend = (r_req_cnt != '0);
  assign o_head     = r_mem[r_rptr];

  assign w_wr_acc = i_wr & ~o_full;
  assign w_rd_acc = i_pop & o_nempty;
  assign w_inc    = w_wr_acc & (i_data[7:0] == DELIM);
  assign w_dec    = w_rd_acc & (o_head[7:0] == DELIM);

  always_comb begin
    w_occ_nxt = r_occ;
    if (w_wr_acc && !w_rd_acc) begin
      w_occ_nxt = r_occ + (DEPTH+1)'(1);
    end else if (!w_wr_acc && w_rd_acc) begin
      w_occ_nxt = r_occ - (DEPTH+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[r_wptr] <= i_data;
    end
  end

  // Space tracks the post-edge occupancy so it is exact in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_occ     <= '0;
      r_space   <= C_CAP;
      r_req_cnt <= '0;
    end else begin
      if (w_wr_acc) r_wptr <= r_wptr + DEPTH'(1);
      if (w_rd_acc) r_rptr <= r_rptr + DEPTH'(1);
      r_occ   <= w_occ_nxt;
      r_space <= C_CAP - w_occ_nxt;
      if (w_inc && !w_dec) begin
        r_req_cnt <= r_req_cnt + (DEPTH+1)'(1);
      end else if (!w_inc && w_dec) begin
        r_req_cnt <= r_req_cnt - (DEPTH+1)'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/req_fifo_mc.sv
// ============================================================================
// Module   : req_fifo_mc
// Brief    : NCH DELIM-terminated request queues drained round-robin, one
//            whole request per grant, to a single valid/ready consumer.
//            Optional per-channel drop counters: REQ_FIFO_MC_DROPCNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module req_fifo_mc
  import req_fifo_pkg::*;
#(
  parameter int         WIDTH = 64,
  parameter int         DEPTH = 3,
  parameter int         NCH   = 4,
  parameter logic [7:0] DELIM = DELIM_DEFAULT
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [NCH-1:0]               wr,
  input  logic [NCH*WIDTH-1:0]         w_data,
  output logic [NCH-1:0]               full,
  output logic [NCH*(DEPTH+1)-1:0]     space,
  output logic [NCH-1:0]               req_pend,
`ifdef REQ_FIFO_MC_DROPCNT_EN
  input  logic                         drop_clr,
  output logic [NCH*16-1:0]            drop_cnt,
`endif
  input  logic                         rd,
  output logic                         r_valid,
  output logic [WIDTH-1:0]             r_data,
  output logic [chan_idx_w(NCH)-1:0]   r_chan,
  output logic                         r_last
);

  localparam int CW = chan_idx_w(NCH);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CW-1:0]    r_lastg;
  logic [CW-1:0]    w_lastg_nxt;
  logic [CW-1:0]    w_chan_nxt;
  logic [CW-1:0]    w_pick;
  logic [CW-1:0]    w_idx;
  logic             w_found;
  logic             w_cur_nempty;
  logic             w_xfer;
  logic [NCH-1:0]   w_nempty;
  logic [NCH-1:0]   w_pop;
  logic [WIDTH-1:0] w_head [NCH];

  generate
    for (genvar c = 0; c < NCH; c++) begin : g_chan
      assign w_pop[c] = w_xfer && (r_chan == CW'(c));

      req_fifo_chan #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .DELIM (DELIM)
      ) u_chan (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_wr       (wr[c]),
        .i_data     (w_data[c*WIDTH +: WIDTH]),
        .i_pop      (w_pop[c]),
        .o_full     (full[c]),
        .o_nempty   (w_nempty[c]),
        .o_space    (space[c*(DEPTH+1) +: (DEPTH+1)]),
        .o_req_pend (req_pend[c]),
        .o_head     (w_head[c])
      );
    end
  endgenerate

  always_comb begin
    r_data       = w_head[0];
    w_cur_nempty = w_nempty[0];
    for (int c = 1; c < NCH; c++) begin
      if (r_chan == CW'(c)) begin
        r_data       = w_head[c];
        w_cur_nempty = w_nempty[c];
      end
    end
  end

  assign r_valid = (r_state == ST_DRAIN) && w_cur_nempty;
  assign r_last  = r_valid && (r_data[7:0] == DELIM);
  assign w_xfer  = r_valid && rd;

  // Round-robin search starting one past the previous grant.
  always_comb begin
    w_found = 1'b0;
    w_pick  = r_lastg;
    w_idx   = '0;
    for (int i = 1; i <= NCH; i++) begin
      w_idx = CW'((int'(r_lastg) + i) % NCH);
      if (!w_found && req_pend[w_idx]) begin
        w_found = 1'b1;
        w_pick  = w_idx;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_chan_nxt  = r_chan;
    w_lastg_nxt = r_lastg;
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_state_nxt = ST_DRAIN;
          w_chan_nxt  = w_pick;
          w_lastg_nxt = w_pick;
        end
      end
      ST_DRAIN: begin
        if (w_xfer && r_last) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_chan  <= '0;
      r_lastg <= CW'(NCH - 1);
    end else begin
      r_state <= w_state_nxt;
      r_chan  <= w_chan_nxt;
      r_lastg <= w_lastg_nxt;
    end
  end

`ifdef REQ_FIFO_MC_DROPCNT_EN
  generate
    for (genvar c = 0; c < NCH; c++) begin : g_drop
      logic [15:0] r_cnt;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_cnt <= '0;
        end else if (drop_clr) begin
          r_cnt <= '0;
        end else if (wr[c] && full[c] && (r_cnt != 16'hFFFF)) begin
          r_cnt <= r_cnt + 16'd1;
        end
      end

      assign drop_cnt[c*16 +: 16] = r_cnt;
    end
  endgenerate
`endif

endmodule

`default_nettype wire

// File: tb/tb_req_fifo_mc.sv
// ============================================================================
// Module   : tb_req_fifo_mc
// Brief    : Scoreboard bench for req_fifo_mc (WIDTH=64, DEPTH=3, NCH=4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_req_fifo_mc;

  localparam int WIDTH = 64;
  localparam int DEPTH = 3;
  localparam int NCH   = 4;

  logic                     clk = 1'b0;
  logic                     reset_n = 1'b0;
  logic [NCH-1:0]           wr = '0;
  logic [NCH*WIDTH-1:0]     w_data = '0;
  logic                     rd = 1'b0;
  logic [NCH-1:0]           full;
  logic [NCH*(DEPTH+1)-1:0] space;
  logic [NCH-1:0]           req_pend;
  logic                     r_valid;
  logic [WIDTH-1:0]         r_data;
  logic [1:0]               r_chan;
  logic                     r_last;
`ifdef REQ_FIFO_MC_DROPCNT_EN
  logic                     drop_clr = 1'b0;
  logic [NCH*16-1:0]        drop_cnt;
`endif

  req_fifo_mc #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .NCH   (NCH),
    .DELIM (8'hEE)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .wr       (wr),
    .w_data   (w_data),
    .full     (full),
    .space    (space),
    .req_pend (req_pend),
`ifdef REQ_FIFO_MC_DROPCNT_EN
    .drop_clr (drop_clr),
    .drop_cnt (drop_cnt),
`endif
    .rd       (rd),
    .r_valid  (r_valid),
    .r_data   (r_data),
    .r_chan   (r_chan),
    .r_last   (r_last)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic [66:0] exp_q [$];
  int          beat_cyc [$];
  logic [66:0] m_got;
  logic [66:0] m_exp;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every accepted output beat is matched against the scoreboard.
  always @(negedge clk) begin
    if (reset_n && r_valid && rd) begin
      m_got = {r_chan, r_data, r_last};
      beat_cyc.push_back(cyc);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL beat: unexpected beat chan %0d data %h last %0b", r_chan, r_data, r_last);
      end else begin
        m_exp = exp_q.pop_front();
        if (m_got !== m_exp) begin
          errors++;
          $display("FAIL beat: got chan %0d data %h last %0b, expected chan %0d data %h last %0b",
                   m_got[66:65], m_got[64:1], m_got[0], m_exp[66:65], m_exp[64:1], m_exp[0]);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_beat(input int c, input logic [63:0] d, input logic last);
    exp_q.push_back({2'(c), d, last});
  endtask

  task automatic put(input int c, input logic [63:0] d);
    wr[c] = 1'b1;
    w_data[c*WIDTH +: WIDTH] = d;
    step();
    wr = '0;
  endtask

  task automatic wait_idle(input string name);
    int k;
    for (k = 0; k < 300; k++) begin
      if (!r_valid && req_pend == '0 && exp_q.size() == 0) break;
      step();
    end
    chk(name, 64'(k < 300), 64'd1);
  endtask

  initial begin
    int n0;
    logic [63:0] d;

    // Reset state
    step(2);
    chk("rst_space_in_reset", 64'(space), 64'h8888);
    reset_n = 1'b1;
    step();
    chk("rst_space", 64'(space), 64'h8888);
    chk("rst_full", 64'(full), 64'h0);
    chk("rst_req_pend", 64'(req_pend), 64'h0);
    chk("rst_valid_chan", 64'({r_valid, r_chan}), 64'h0);

    // Single three-word request on channel 2
    rd = 1'b1;
    expect_beat(2, 64'h2222_0000_0000_0001, 1'b0);
    expect_beat(2, 64'h2222_0000_0000_0002, 1'b0);
    expect_beat(2, 64'h2222_0000_0000_03EE, 1'b1);
    put(2, 64'h2222_0000_0000_0001);
    put(2, 64'h2222_0000_0000_0002);
    put(2, 64'h2222_0000_0000_03EE);
    chk("t1_req_pend", 64'(req_pend), 64'h4);
    chk("t1_valid_before_grant", 64'(r_valid), 64'h0);
    chk("t1_space2", 64'(space[11:8]), 64'd5);
    step();
    chk("t1_grant", 64'({r_valid, r_chan}), 64'b110);
    wait_idle("t1_idle_timeout");
    chk("t1_back_to_back", 64'(beat_cyc[$] - beat_cyc[$-2]), 64'd2);
    chk("t1_req_pend_clear", 64'(req_pend), 64'h0);

    // Round-robin order 0,1,3 then 0, one bubble between single-word requests
    n0 = beat_cyc.size();
    expect_beat(0, 64'hA0A0_0000_0000_00EE, 1'b1);
    expect_beat(1, 64'hB1B1_0000_0000_00EE, 1'b1);
    expect_beat(3, 64'hC3C3_0000_0000_00EE, 1'b1);
    put(0, 64'hA0A0_0000_0000_00EE);
    put(1, 64'hB1B1_0000_0000_00EE);
    put(3, 64'hC3C3_0000_0000_00EE);
    wait_idle("t2_idle_timeout");
    chk("t2_beats", 64'(beat_cyc.size() - n0), 64'd3);
    if (beat_cyc.size() - n0 == 3) begin
      chk("t2_bubble_a", 64'(beat_cyc[n0+1] - beat_cyc[n0]), 64'd2);
      chk("t2_bubble_b", 64'(beat_cyc[n0+2] - beat_cyc[n0+1]), 64'd2);
    end
    expect_beat(0, 64'hD0D0_0000_0000_01EE, 1'b1);
    put(0, 64'hD0D0_0000_0000_01EE);
    wait_idle("t2_wrap_idle_timeout");

    // Fill channel 1; the ninth write is dropped
    rd = 1'b0;
    for (int i = 0; i < 9; i++) begin
      d = 64'h1111_0000_0000_0000 | 64'(i << 8) | ((i == 7) ? 64'hEE : 64'(i));
      if (i < 8) expect_beat(1, d, i == 7);
      put(1, d);
      if (i == 7) begin
        chk("t3_full_after_8", 64'(full), 64'h2);
        chk("t3_space_after_8", 64'(space[7:4]), 64'd0);
      end
    end
    chk("t3_full_after_9", 64'(full), 64'h2);
    chk("t3_space_after_9", 64'(space[7:4]), 64'd0);
`ifdef REQ_FIFO_MC_DROPCNT_EN
    chk("t3_drop_cnt", 64'(drop_cnt), 64'h0000_0000_0001_0000);
`endif
    rd = 1'b1;
    wait_idle("t3_idle_timeout");
    chk("t3_space_drained", 64'(space), 64'h8888);

    // Drain channel 0 with rd 1,0,1 while channel 0 keeps receiving writes
    rd = 1'b0;
    expect_beat(0, 64'hAAAA_0000_0000_0010, 1'b0);
    expect_beat(0, 64'hAAAA_0000_0000_0011, 1'b0);
    expect_beat(0, 64'hAAAA_0000_0000_12EE, 1'b1);
    expect_beat(0, 64'hBBBB_0000_0000_0020, 1'b0);
    expect_beat(0, 64'hBBBB_0000_0000_0021, 1'b0);
    expect_beat(0, 64'hBBBB_0000_0000_22EE, 1'b1);
    put(0, 64'hAAAA_0000_0000_0010);
    put(0, 64'hAAAA_0000_0000_0011);
    put(0, 64'hAAAA_0000_0000_12EE);
    step();
    chk("t4_grant", 64'({r_valid, r_chan}), 64'b100);
    rd = 1'b1;
    put(0, 64'hBBBB_0000_0000_0020);
    chk("t4_space_rw", 64'(space[3:0]), 64'd5);
    rd = 1'b0;
    put(0, 64'hBBBB_0000_0000_0021);
    chk("t4_space_w", 64'(space[3:0]), 64'd4);
    rd = 1'b1;
    put(0, 64'hBBBB_0000_0000_22EE);
    chk("t4_space_rw2", 64'(space[3:0]), 64'd4);
    step();
    chk("t4_space_r", 64'(space[3:0]), 64'd5);
    wait_idle("t4_idle_timeout");
    chk("t4_space_empty", 64'(space), 64'h8888);

    // Asynchronous reset in the middle of a drain
    rd = 1'b0;
    put(2, 64'h5555_0000_0000_0030);
    put(2, 64'h5555_0000_0000_0031);
    put(2, 64'h5555_0000_0000_32EE);
    step();
    chk("t5_grant", 64'({r_valid, r_chan}), 64'b110);
    #3 reset_n = 1'b0;
    #1;
    chk("t5_valid_async", 64'(r_valid), 64'h0);
    chk("t5_space_async", 64'(space), 64'h8888);
    chk("t5_req_pend_async", 64'(req_pend), 64'h0);
    step();
    reset_n = 1'b1;
    step(2);
    chk("t5_idle_after", 64'({r_valid, r_chan}), 64'h0);

    // DELIM written to channel 3 as its previous DELIM leaves
    expect_beat(3, 64'h6666_0000_0000_40EE, 1'b1);
    expect_beat(3, 64'h7777_0000_0000_41EE, 1'b1);
    put(3, 64'h6666_0000_0000_40EE);
    step();
    chk("t6_grant", 64'({r_valid, r_chan}), 64'b111);
    rd = 1'b1;
    put(3, 64'h7777_0000_0000_41EE);
    chk("t6_req_pend_kept", 64'(req_pend), 64'h8);
    chk("t6_idle_bubble", 64'(r_valid), 64'h0);
    wait_idle("t6_idle_timeout");
    chk("t6_req_pend_clear", 64'(req_pend), 64'h0);

    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
